act_memory_3d: RTL and testbench

- 3-D activation storage (entry × y × x) for CNN layer blocks, e.g. the max-pool layer uses one for input feature maps and one for output feature maps.
- One synchronous write port and one combinational read port, each addressed by a separate entry/y/x index triple.
- Unwritten locations read as zero, tracked by a per-word valid bit.

---
 rtl/act_memory_3d.sv | 95 +++++++++
 tb/tb_act_memory_3d.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/act_memory_3d.sv
// act_memory_3d: entry x y x x activation store with one synchronous write port and one combinational read port.
// Never-written words read as zero. Defining ACT_MEMORY_DEBUG_EN (with DEBUG != 0) enables write tracing.
module act_memory_3d #(
    parameter int DEBUG     = 0,
    parameter     NAME      = "ACT_MEM",
    parameter int DIM       = 26,
    parameter int DATA_SIZE = 64,
    parameter int ENTRY_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic [15:0]          index_entry,
    input  logic [15:0]          index_y,
    input  logic [15:0]          index_x,
    input  logic [15:0]          read_index_entry,
    input  logic [15:0]          read_index_y,
    input  logic [15:0]          read_index_x,
    output logic [DATA_SIZE-1:0] out_data
);
    localparam int          DEPTH   = ENTRY_NUM * DIM * DIM;
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ENTRY_W = 32'(ENTRY_NUM);
    localparam logic [31:0] DIM_W   = 32'(DIM);
    localparam logic [31:0] PLANE_W = 32'(DIM * DIM);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [31:0]          wr_addr;
    logic [31:0]          rd_addr;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_en;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;

    // Each field is range-checked on its own so an aliasing linear address never passes.
    always_comb begin
        wr_addr     = 32'(index_entry) * PLANE_W + 32'(index_y) * DIM_W + 32'(index_x);
        rd_addr     = 32'(read_index_entry) * PLANE_W + 32'(read_index_y) * DIM_W
                    + 32'(read_index_x);
        wr_in_range = (32'(index_entry) < ENTRY_W) && (32'(index_y) < DIM_W)
                   && (32'(index_x) < DIM_W);
        rd_in_range = (32'(read_index_entry) < ENTRY_W) && (32'(read_index_y) < DIM_W)
                   && (32'(read_index_x) < DIM_W);
        wr_idx      = wr_in_range ? AW'(wr_addr) : '0;
        rd_idx      = rd_in_range ? AW'(rd_addr) : '0;
        wr_en       = rst_n && write && wr_in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Data words carry no reset; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_comb begin
        out_data = '0;
        if (rst_n && rd_in_range && valid[rd_idx]) begin
            out_data = mem[rd_idx];
        end
    end

    if ((DEBUG != 0) && ($bits(NAME) < 8)) begin : g_name_check
        $error("act_memory_3d: NAME must be a non-empty string");
    end

`ifdef ACT_MEMORY_DEBUG_EN
    if (DEBUG != 0) begin : g_trace
        always @(posedge clk) begin
            if (rst_n && write) begin
                if (wr_in_range) begin
                    $display("%0s: write [%0d][%0d][%0d] = %f", NAME, index_entry, index_y,
                             index_x, $bitstoreal(64'(in_data)));
                end else begin
                    $display("%0s: OOB write [%0d][%0d][%0d]", NAME, index_entry, index_y,
                             index_x);
                end
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_act_memory_3d.sv
// Directed bench for act_memory_3d: a table of write/read vectors on the full-size memory
// plus hand sequences for same-edge timing, a full sweep and mid-sweep reset on a 2x4x4 instance.
module tb_act_memory_3d;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [63:0] in_data;
    logic [15:0] index_entry, index_y, index_x;
    logic [15:0] read_index_entry, read_index_y, read_index_x;
    logic [63:0] out_data;

    logic        s_write;
    logic [63:0] s_in;
    logic [15:0] s_e, s_y, s_x, s_re, s_ry, s_rx;
    logic [63:0] s_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    act_memory_3d dut (
        .clk(clk), .rst_n(rst_n), .write(write), .in_data(in_data),
        .index_entry(index_entry), .index_y(index_y), .index_x(index_x),
        .read_index_entry(read_index_entry), .read_index_y(read_index_y),
        .read_index_x(read_index_x), .out_data(out_data)
    );

    act_memory_3d #(.DIM(4), .ENTRY_NUM(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .write(s_write), .in_data(s_in),
        .index_entry(s_e), .index_y(s_y), .index_x(s_x),
        .read_index_entry(s_re), .read_index_y(s_ry), .read_index_x(s_rx),
        .out_data(s_out)
    );

    typedef struct {
        logic        wr;
        logic [63:0] d;
        logic [15:0] e, y, x;
        logic [15:0] re, ry, rx;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [63:0] d,
                                input int e, input int y, input int x,
                                input int re, input int ry, input int rx,
                                input logic [63:0] exp, input string nm);
        vec_t v;
        v.wr = wr; v.d = d;
        v.e = 16'(e); v.y = 16'(y); v.x = 16'(x);
        v.re = 16'(re); v.ry = 16'(ry); v.rx = 16'(rx);
        v.exp = exp; v.nm = nm;
        return v;
    endfunction

    task automatic set_read(input int e, input int y, input int x);
        read_index_entry = 16'(e); read_index_y = 16'(y); read_index_x = 16'(x);
    endtask

    task automatic set_s_rd(input int a);
        s_re = 16'(a / 16); s_ry = 16'((a / 4) % 4); s_rx = 16'(a % 4);
    endtask

    task automatic set_s_wr(input int a, input logic [63:0] d);
        s_write = 1'b1; s_in = d;
        s_e = 16'(a / 16); s_y = 16'((a / 4) % 4); s_x = 16'(a % 4);
    endtask

    initial begin
        // Each vector's expectation is the read value just before its own write edge.
        vecs.push_back(mk(1, 64'h4000000000000000, 3, 5, 7,  3, 5, 7, 64'h0, "pre_write_357"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   3, 5, 7,   64'h4000000000000000, "read_357"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   3, 5, 6,   64'h0,  "neighbour_356"));
        vecs.push_back(mk(1, 64'hA5, 1, 1, 1,   1, 1, 1,   64'h0,  "pre_a5_111"));
        vecs.push_back(mk(1, 64'h5A, 1, 1, 1,   1, 1, 1,   64'hA5, "a5_111"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   1, 1, 1,   64'h5A, "overwrite_111"));
        vecs.push_back(mk(1, 64'hFF, 16, 0, 0,  0, 0, 0,   64'h0,  "oob_entry_w"));
        vecs.push_back(mk(1, 64'hFF, 0, 26, 0,  0, 0, 0,   64'h0,  "oob_y_w"));
        vecs.push_back(mk(1, 64'hFF, 0, 0, 26,  0, 0, 0,   64'h0,  "oob_x_w"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   0, 0, 0,   64'h0,  "after_oob_000"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   0, 1, 0,   64'h0,  "alias_010"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   1, 0, 0,   64'h0,  "alias_100"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   16, 0, 0,  64'h0,  "oob_read_e"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   0, 0, 26,  64'h0,  "oob_read_x"));
        vecs.push_back(mk(1, 64'h77, 15, 25, 25, 15, 25, 25, 64'h0, "pre_max"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   15, 25, 25, 64'h77, "max_corner"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   3, 5, 7,   64'h4000000000000000, "undisturbed_357"));
        vecs.push_back(mk(0, 64'h0,  0, 0, 0,   3, 5, 7,   64'h4000000000000000, "oob_idx_read"));
        // Last vector reads [3][5][7] via an out-of-range x whose linear address would alias it.
        vecs[vecs.size()-1].ry = 16'd4; vecs[vecs.size()-1].rx = 16'd33;
        vecs[vecs.size()-1].exp = 64'h0;

        rst_n = 1'b0; write = 1'b0; in_data = '0;
        index_entry = '0; index_y = '0; index_x = '0;
        set_read(0, 0, 0);
        s_write = 1'b0; s_in = '0; s_e = '0; s_y = '0; s_x = '0;
        set_s_rd(0);

        repeat (2) @(negedge clk);
        #1 check("in_reset_000", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_000", out_data, 64'h0);
        set_read(15, 25, 25);
        #1 check("reset_max", out_data, 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            write = vecs[i].wr; in_data = vecs[i].d;
            index_entry = vecs[i].e; index_y = vecs[i].y; index_x = vecs[i].x;
            set_read(vecs[i].re, vecs[i].ry, vecs[i].rx);
            #1 check(vecs[i].nm, out_data, vecs[i].exp);
        end
        @(negedge clk);
        write = 1'b0;

        // Same-address write: old value up to the edge, new value right after it.
        set_read(2, 2, 2);
        write = 1'b1; in_data = 64'h33; index_entry = 16'd2; index_y = 16'd2; index_x = 16'd2;
        #1 check("rdw_before_edge", out_data, 64'h0);
        @(posedge clk);
        #1 check("rdw_after_edge", out_data, 64'h33);
        @(negedge clk);
        write = 1'b0;

        // Full sweep on the small instance.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            set_s_wr(a, 64'(a + 1));
        end
        @(negedge clk);
        s_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_s_rd(a);
            #1 check($sformatf("sweep_%0d", a), s_out, 64'(a + 1));
        end

        // Rewrite sweep, reset mid-way; writes while reset is low must be ignored.
        for (int a = 0; a < 24; a++) begin
            @(negedge clk);
            set_s_wr(a, 64'(a + 100));
            if (a == 16) begin
                rst_n = 1'b0;
                set_s_rd(3);
                #1 check("s_out_in_reset", s_out, 64'h0);
                check("out_in_reset", out_data, 64'h0);
            end
        end
        @(negedge clk);
        s_write = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            set_s_rd(a);
            #1 check($sformatf("post_reset_%0d", a), s_out, 64'h0);
        end
        set_read(3, 5, 7);
        #1 check("big_post_reset_357", out_data, 64'h0);
        set_read(2, 2, 2);
        #1 check("big_post_reset_222", out_data, 64'h0);

        // Rewrite after reset becomes visible again.
        @(negedge clk);
        set_s_wr(31, 64'hBEEF);
        @(negedge clk);
        s_write = 1'b0;
        set_s_rd(31);
        #1 check("s_rewrite_31", s_out, 64'hBEEF);
        set_s_rd(30);
        #1 check("s_neighbour_30", s_out, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
